button_press_filter: RTL
========================

BUTTON_PRESS_FILTER -- requirements
Module: button_press_filter

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 4 (range 2-255), which is the number of consecutive synchronized samples that must disagree with the debounced level before that level changes.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 4 (power of two, 2-16), which is the depth of the press-event queue.
REQ-003 clk  input  1  single clock; the game tick clock. All logic is on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 raw_buttons  input  12  asynchronous button levels from both NES decoders; bit i = button index i, 1 = pressed.
REQ-006 press_ready  input  1  the consumer accepts the head event this cycle.
REQ-007 press_valid  output  1  the head of the queue holds a press event.
REQ-008 press_code  output  4  button index 0-11 of the head event.
REQ-009 held  output  12  debounced button levels.
REQ-010 fifo_count  output  5  number of queued events, 0 to FIFO_DEPTH.
REQ-011 drop_count  output  8  count of lost or rejected presses; saturates at 255.

Function
REQ-012 Each raw_buttons bit SHALL pass through a 2-flop synchronizer (sync1, then sync2) before any other use.
REQ-013 Debounce, per bit:
- When sync2 != held, the bit's counter increments.
- When sync2 != held and the counter equals DEBOUNCE_CYCLES-1, held toggles and the counter clears on that edge.
- When sync2 == held, the counter clears.
REQ-014 A stable raw change SHALL therefore appear on held at rising edge index DEBOUNCE_CYCLES+1, counting the first edge that samples the new level as edge 0.
REQ-015 A raw pulse shorter than DEBOUNCE_CYCLES synchronized samples SHALL leave held unchanged.
REQ-016 On the edge where held[i] goes 0->1, pending[i] SHALL be set; a 1->0 transition SHALL produce no event.
REQ-017 If pending[i] is already set when a new 0->1 edge of held[i] occurs, the new press is lost and drop_count SHALL increment.
REQ-018 Each cycle, the lowest-index set pending bit SHALL be written to the queue and cleared, provided the queue is not full or a pop occurs in the same cycle; otherwise it stays pending.
- Only one push per cycle.
- Simultaneous presses drain in ascending index order.
REQ-019 The queue SHALL be FIFO with show-ahead behaviour:
- press_valid = (fifo_count != 0).
- press_code shows the oldest entry.
- A pop occurs when press_valid && press_ready.
REQ-020 Push and pop in the same cycle SHALL leave fifo_count unchanged, including when the queue is full; a pop on an empty queue SHALL be ignored.
REQ-021 Latency from a held 0->1 edge to press_valid rising, with an empty queue and no other pending bits, SHALL be 2 edges.
REQ-022 press_code SHALL only take values 0-11, and SHALL hold stable while press_valid && !press_ready.
REQ-023 drop_count SHALL saturate at 255 and never wrap.

Reset
REQ-024 While rst=1 at a rising edge, the following SHALL clear to 0: sync1, sync2, held, all debounce counters, pending, the queue pointers, fifo_count, press_valid, press_code and drop_count.
REQ-025 Reset asserted mid-operation SHALL discard queued and pending events without emitting them.
REQ-026 A button physically held through reset SHALL produce one press at DEBOUNCE_CYCLES+3 edges after rst deasserts.

Configuration
REQ-027 Macro CHORD_REJECT_EN:
- When defined: a held[i] 0->1 edge occurring while any other held[j] (j != i) is already 1 SHALL NOT set pending[i], and drop_count SHALL increment instead. Edges of several bits in the same cycle with no prior held bit are all accepted.
- When undefined: every 0->1 edge is accepted per REQ-016/017.

Verification
REQ-028 DEBOUNCE_CYCLES=4; raw_buttons[3] rises and stays high -> held[3]=1 after edge 5, press_valid=1 with press_code=3 after edge 7, and the event pops when press_ready=1.
REQ-029 raw_buttons[5] high for 3 cycles then low -> held, press_valid and drop_count all stay 0.
REQ-030 raw_buttons[0], [7] and [11] rise in the same cycle, press_ready=1 -> press_code sequence 0, 7, 11 on consecutive valid cycles.
REQ-031 press_ready=0; 6 separate presses of different buttons with FIFO_DEPTH=4 -> fifo_count=4 and 2 pending; then press_ready=1 -> all 6 codes delivered in order, drop_count=0.
REQ-032 CHORD_REJECT_EN defined: hold button 1, then press button 2 -> only code 1 is emitted and drop_count=1; undefined -> codes 1 then 2, drop_count=0.
REQ-033 rst pulsed while fifo_count=3 -> press_valid=0, fifo_count=0 and drop_count=0 on the next cycle.

Source files
------------

// File: rtl/button_press_filter.sv
// button_press_filter: synchronizes and debounces twelve NES button lines,
// turns debounced rising edges into press events and queues them in a small
// show-ahead FIFO for the game logic.
// Optional build macro CHORD_REJECT_EN: a new press while another button is
// already held is rejected and counted as a drop instead of being queued.
module button_press_filter #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] raw_buttons,
  input  logic        press_ready,
  output logic        press_valid,
  output logic [3:0]  press_code,
  output logic [11:0] held,
  output logic [4:0]  fifo_count,
  output logic [7:0]  drop_count
);

  localparam int         PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0] CNT_FULL = 5'(FIFO_DEPTH);

  logic [11:0]   sync1_q, sync2_q;
  logic [11:0]   held_q, held_d, held_prev_q;
  logic [7:0]    cnt_q [12];
  logic [7:0]    cnt_d [12];
  logic [11:0]   pending_q, pending_d;
  logic [11:0]   rise, chord_blk, accept, drop_vec, push_onehot;
  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [4:0]    count_q, count_d;
  logic [7:0]    drop_q, drop_d;
  logic [3:0]    push_idx;
  logic          push_any, push, pop;

  function automatic logic [3:0] popcnt12(input logic [11:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 12; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {5'b00000, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // Per-bit debounce: count disagreeing samples, flip held on the last one.
  always_comb begin
    held_d = held_q;
    for (int i = 0; i < 12; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != held_q[i]) begin
        if (cnt_q[i] == CNT_LAST) held_d[i] = ~held_q[i];
        else                      cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  // Press detection on the registered held edge, with optional chord blocking.
  always_comb begin
    rise = held_q & ~held_prev_q;
`ifdef CHORD_REJECT_EN
    for (int i = 0; i < 12; i++) chord_blk[i] = |(held_prev_q & ~(12'd1 << i));
`else
    chord_blk = '0;
`endif
    drop_vec = rise & (pending_q | chord_blk);
    accept   = rise & ~pending_q & ~chord_blk;
  end

  // Lowest-index pending bit is the push candidate; one push per cycle.
  always_comb begin
    push_any = 1'b0;
    push_idx = '0;
    for (int i = 11; i >= 0; i--) begin
      if (pending_q[i]) begin
        push_any = 1'b1;
        push_idx = 4'(i);
      end
    end
    pop         = press_valid && press_ready;
    push        = push_any && ((count_q != CNT_FULL) || pop);
    push_onehot = push ? (12'd1 << push_idx) : '0;
    pending_d   = (pending_q & ~push_onehot) | accept;
    drop_d      = sat_add8(drop_q, popcnt12(drop_vec));
    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  // Control and status state, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      held_q      <= '0;
      held_prev_q <= '0;
      pending_q   <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      drop_q      <= '0;
      for (int i = 0; i < 12; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q     <= raw_buttons;
      sync2_q     <= sync1_q;
      held_q      <= held_d;
      held_prev_q <= held_q;
      pending_q   <= pending_d;
      count_q     <= count_d;
      drop_q      <= drop_d;
      for (int i = 0; i < 12; i++) cnt_q[i] <= cnt_d[i];
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Queue storage; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wptr_q] <= push_idx;
  end

  assign press_valid = (count_q != 5'd0);
  assign press_code  = press_valid ? mem_q[rptr_q] : 4'd0;
  assign held        = held_q;
  assign fifo_count  = count_q;
  assign drop_count  = drop_q;

endmodule
